// File: rtl/sram_wide_port_ctrl.sv
// sram_wide_port_ctrl: aggregates a narrow write stream into wide SRAM words and serializes wide reads.
// Optional partial-group flush port enabled by macro SRAM_CTRL_PARTIAL_FLUSH_EN. Rev 1.0
`default_nettype none

module sram_wide_port_ctrl #(
  parameter int DATA_W  = 16,
  parameter int FETCH_W = 4,
  parameter int ADDR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
`ifdef SRAM_CTRL_PARTIAL_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic                      rd_req_valid,
  output logic                      rd_req_ready,
  input  logic [ADDR_W-1:0]         rd_req_addr,
  output logic                      rd_data_valid,
  input  logic                      rd_data_ready,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         mem_addr_in_bank,
  output logic                      mem_cen_in_bank,
  output logic                      mem_wen_in_bank,
  output logic [FETCH_W*DATA_W-1:0] mem_data_in_bank,
  input  logic [FETCH_W*DATA_W-1:0] mem_data_out_bank
);

  localparam int IDX_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int CNT_W = $clog2(FETCH_W + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_RD_SER  = 2'd2;

  logic [1:0]              r_state;
  logic [1:0]              w_next_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [ADDR_W-1:0]       r_waddr;
  logic [DATA_W-1:0]       r_wbuf   [FETCH_W];
  logic [DATA_W-1:0]       r_shadow [FETCH_W];
  logic [FETCH_W*DATA_W-1:0] w_wide;

  logic w_en;
  logic w_pending;
  logic w_wr_hs;
  logic w_rd_hs;
  logic w_rd_dhs;
  logic w_commit;
  logic w_flush_hit;
  logic w_last_word;

  // Readies and bank strobes drop while reset is held so every output reads 0.
  assign w_en        = clk_en & ~rst;
  assign w_pending   = (r_cnt == CNT_W'(FETCH_W));
  assign wr_ready    = w_en & (r_cnt < CNT_W'(FETCH_W));
  assign w_wr_hs     = wr_valid & wr_ready;
  assign w_rd_hs     = rd_req_valid & rd_req_ready;
  assign w_rd_dhs    = clk_en & rd_data_valid & rd_data_ready;
  assign w_commit    = w_en & w_pending & ((r_state == S_IDLE) || (r_state == S_RD_SER));
  assign w_last_word = (r_idx == IDX_W'(FETCH_W - 1));

`ifdef SRAM_CTRL_PARTIAL_FLUSH_EN
  assign w_flush_hit = w_en & flush & (r_cnt != '0) & ~w_pending;
`else
  assign w_flush_hit = 1'b0;
`endif

  for (genvar g = 0; g < FETCH_W; g++) begin : g_pack
    assign w_wide[g*DATA_W +: DATA_W] = r_wbuf[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_rd_hs) w_next_state = S_RD_WAIT;
      S_RD_WAIT: if (clk_en) w_next_state = S_RD_SER;
      S_RD_SER:  if (w_rd_dhs && w_last_word) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // A pending commit blocks rd_req_ready, so commit and read never share a cycle.
  always_comb begin
    rd_req_ready     = 1'b0;
    rd_data_valid    = 1'b0;
    rd_data          = '0;
    mem_cen_in_bank  = 1'b0;
    mem_wen_in_bank  = 1'b0;
    mem_addr_in_bank = '0;
    mem_data_in_bank = '0;
    case (r_state)
      S_IDLE: rd_req_ready = w_en & ~w_pending;
      S_RD_SER: begin
        rd_data_valid = 1'b1;
        rd_data       = r_shadow[r_idx];
      end
      default: ;
    endcase
    if (w_commit) begin
      mem_cen_in_bank  = 1'b1;
      mem_wen_in_bank  = 1'b1;
      mem_addr_in_bank = r_waddr;
      mem_data_in_bank = w_wide;
    end else if (w_rd_hs) begin
      mem_cen_in_bank  = 1'b1;
      mem_addr_in_bank = rd_req_addr;
    end
  end

  // Slots are cleared on commit so a flushed partial group writes zeros in unfilled slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_waddr <= '0;
      for (int i = 0; i < FETCH_W; i++) r_wbuf[i] <= '0;
    end else begin
      if (w_wr_hs) begin
        r_wbuf[r_cnt[IDX_W-1:0]] <= wr_data;
        if (r_cnt == '0) r_waddr <= wr_addr;
      end
      if (w_commit) begin
        r_cnt <= '0;
        for (int i = 0; i < FETCH_W; i++) r_wbuf[i] <= '0;
      end else if (w_flush_hit) begin
        r_cnt <= CNT_W'(FETCH_W);
      end else if (w_wr_hs) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      for (int i = 0; i < FETCH_W; i++) r_shadow[i] <= '0;
    end else if (clk_en) begin
      if (r_state == S_RD_WAIT) begin
        r_idx <= '0;
        for (int i = 0; i < FETCH_W; i++) r_shadow[i] <= mem_data_out_bank[i*DATA_W +: DATA_W];
      end else if (w_rd_dhs) begin
        r_idx <= w_last_word ? '0 : r_idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/sram_wide_port_ctrl.md
Name: sram_wide_port_ctrl

Overview:
- Initiator-side controller for a single-port wide-fetch SRAM bank wrapper (FETCH_W words of DATA_W bits per address, 1-cycle read latency).
- Write side: aggregates a 16-bit word stream into wide words and commits them to the bank.
- Read side: issues wide reads and serializes the returned wide word onto a 16-bit ready/valid stream.
- Sits between the memory-tile address generators and the bank wrapper.

Parameters:
- DATA_W, 16, word width.
- FETCH_W, 4, words per SRAM address.
- ADDR_W, 8, SRAM (wide) address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- clk_en  in  1  global enable; when low all state holds
- wr_valid  in  1  write word valid
- wr_ready  out  1  write word accepted when wr_valid&wr_ready
- wr_data  in  DATA_W  write word
- wr_addr  in  ADDR_W  wide address, sampled only on the first word of a group
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accepted
- rd_req_addr  in  ADDR_W  wide read address
- rd_data_valid  out  1  serialized read word valid
- rd_data_ready  in  1  consumer ready
- rd_data  out  DATA_W  serialized read word
- mem_addr_in_bank  out  ADDR_W  to bank
- mem_cen_in_bank  out  1  chip enable, active-high at this interface
- mem_wen_in_bank  out  1  write enable, active-high
- mem_data_in_bank  out  FETCH_W*DATA_W  word i in bits [i*DATA_W +: DATA_W]
- mem_data_out_bank  in  FETCH_W*DATA_W  same packing; valid 1 cycle after a read

Behaviour:
Reset (async, any time):
- State IDLE, aggregation count 0, serializer index 0.
- All outputs 0, including mem_cen/mem_wen.
- Reset mid-serialization or mid-aggregation discards the data.

Gating:
- All state changes require clk_en=1.
- clk_en=0 forces wr_ready, rd_req_ready, mem_cen_in_bank and mem_wen_in_bank to 0.
- rd_data_valid and rd_data hold their values while clk_en=0.

Write aggregation:
- On a handshake, wr_data is stored in slot cnt and cnt increments. On the cnt=0 handshake, wr_addr is latched.
- wr_ready = clk_en & (cnt<FETCH_W).
- cnt==FETCH_W means "pending commit".

Commit:
- Allowed when pending and state ∈ {IDLE, RD_SER}.
- Drives mem_cen=1, mem_wen=1, latched addr, and packed data for one cycle (combinational from registered state).
- cnt returns to 0 the next cycle, so wr_ready reasserts then.
- Minimum throughput: FETCH_W+1 cycles per group.

Read FSM:
- IDLE:
  - rd_req_ready = clk_en & ~pending.
  - Commit has priority: a simultaneous pending commit and rd_req_valid commits first, and the read waits.
  - On a read handshake: drive mem_cen=1, mem_wen=0, mem_addr=rd_req_addr, and go to RD_WAIT.
- RD_WAIT:
  - No bank access.
  - Capture mem_data_out_bank into the shadow register, set idx=0, go to RD_SER.
- RD_SER:
  - rd_data_valid=1, rd_data=shadow[idx]. On a handshake idx increments.
  - A handshake at idx=FETCH_W-1 returns to IDLE.
  - rd_req_ready=0 in this state, so there is no back-to-back overlap.
  - Backpressure holds rd_data stable.
- Latency: read handshake at cycle N gives the first rd_data_valid at N+2.

Ordering and boundaries:
- Read-after-write to the same address returns the new data once the commit precedes the read handshake, which the commit priority guarantees for a full group.
- Partial groups are never committed (see Optional Feature).
- idx and cnt wrap to 0 exactly at FETCH_W.

Optional Feature:
- Macro: SRAM_CTRL_PARTIAL_FLUSH_EN.
- Enabled:
  - Adds input port "flush" (1 bit).
  - flush=1 with 0<cnt<FETCH_W marks the group pending.
  - Unfilled slots are written as 0.
  - Commit then follows the normal rules.
  - flush with cnt=0 or a full group has no effect.
  - A flush in the same cycle as a write handshake includes that word.
- Disabled: the port is absent, and only full groups commit.

Test Plan:
- Write 0x0001..0x0004 with wr_addr=0x05 on word 1 -> one cycle with cen=1, wen=1, addr=0x05, data_in=0x0004_0003_0002_0001; wr_ready low for exactly 1 cycle.
- Read addr 0x05 (bank model returns the stored word) -> rd_data 0x0001, 0x0002, 0x0003, 0x0004 on 4 consecutive cycles; first rd_data_valid 2 cycles after the request handshake.
- Full write group pending and rd_req_valid in the same IDLE cycle -> write commit first, read handshake next cycle, read returns the just-written data.
- rd_data_ready toggled 1,0,0,1,... during RD_SER -> no word dropped or duplicated; rd_data stable while stalled.
- rst asserted while idx=2 in RD_SER -> all outputs 0 immediately; afterwards rd_req_ready=1 and cnt=0.
- With SRAM_CTRL_PARTIAL_FLUSH_EN: write 0xAAAA, 0xBBBB then flush -> commit data_in=0x0000_0000_BBBB_AAAA.
